// File: rtl/matrix_column_scanner.sv
// Scan controller for the 5x7 active-low LED matrix. Latches five column images per
// frame, blanks before each column, drives one column at a time, and can flash rows.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_OFF   | scan disabled, outputs blank
// ST_BLANK | inter-column gap, outputs blank for BLANK_CYCLES cycles
// ST_DRIVE | column col_idx selected for DWELL_CYCLES cycles
module matrix_column_scanner #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_FRAMES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       blink_en,
    input  logic [6:0] column_4,
    input  logic [6:0] column_3,
    input  logic [6:0] column_2,
    input  logic [6:0] column_1,
    input  logic [6:0] column_0,
    output logic [6:0] row,
    output logic [4:0] col_sel,
    output logic       frame_start
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int PW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] DWELL_LAST = PW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      col_idx_q, col_idx_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [4:0][6:0] shadow_q, shadow_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_vis_q, blink_vis_d;
    logic [6:0]      row_q, row_d;
    logic [4:0]      col_sel_q, col_sel_d;
    logic            frame_start_q, frame_start_d;
    logic            load_frame;
    logic            frame_end;

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        presc_d       = presc_q + 1'b1;
        shadow_d      = shadow_q;
        frame_cnt_d   = frame_cnt_q;
        blink_vis_d   = blink_vis_q;
        frame_start_d = 1'b0;
        row_d         = 7'h7F;
        col_sel_d     = 5'h1F;
        load_frame    = 1'b0;
        frame_end     = 1'b0;

        case (state_q)
            ST_OFF: begin
                presc_d = '0;
                if (enable) begin
                    state_d    = ST_BLANK;
                    col_idx_d  = 3'd4;
                    load_frame = 1'b1;
                end
            end
            ST_BLANK: begin
                if (presc_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    presc_d = '0;
                end
            end
            ST_DRIVE: begin
                if (presc_q == DWELL_LAST) begin
                    state_d = ST_BLANK;
                    presc_d = '0;
                    if (col_idx_q == 3'd0) begin
                        col_idx_d  = 3'd4;
                        load_frame = 1'b1;
                        frame_end  = 1'b1;
                    end else begin
                        col_idx_d = col_idx_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_OFF;
                presc_d = '0;
            end
        endcase

        // Disable overrides whatever the scan was about to do on this edge.
        if (!enable) begin
            state_d    = ST_OFF;
            presc_d    = '0;
            load_frame = 1'b0;
            frame_end  = 1'b0;
        end

        if (!blink_en) begin
            frame_cnt_d = '0;
            blink_vis_d = 1'b1;
        end else if (frame_end) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_vis_d = ~blink_vis_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        if (load_frame) begin
            shadow_d      = {column_4, column_3, column_2, column_1, column_0};
            frame_start_d = 1'b1;
        end

        // Outputs are computed from next-state values so they change with the state.
        if (state_d == ST_DRIVE) begin
            col_sel_d = ~(5'b00001 << col_idx_d);
            if (blink_vis_d) begin
                row_d = shadow_d[col_idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_OFF;
            col_idx_q     <= 3'd4;
            presc_q       <= '0;
            shadow_q      <= {5{7'h7F}};
            frame_cnt_q   <= '0;
            blink_vis_q   <= 1'b1;
            row_q         <= 7'h7F;
            col_sel_q     <= 5'h1F;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            presc_q       <= presc_d;
            shadow_q      <= shadow_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_vis_q   <= blink_vis_d;
            row_q         <= row_d;
            col_sel_q     <= col_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row         = row_q;
    assign col_sel     = col_sel_q;
    assign frame_start = frame_start_q;

endmodule
